// File: rtl/max_pool_2x2_pkg.sv
// Shared CNN stage definitions: activation width, feature-map geometry, pixel type.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package max_pool_2x2_pkg;

    localparam int DATA_WIDTH = 21;
    localparam int IN_DIM     = 48;
    localparam int OUT_DIM    = IN_DIM / 2;

    // Coordinate widths seen on the stage boundaries.
    localparam int CNT_W  = 6;
    localparam int OCNT_W = 5;

    typedef logic signed [DATA_WIDTH-1:0] pixel_t;

    // Signed max where a tie keeps the operand that arrived first.
    function automatic pixel_t pool_max(input pixel_t first, input pixel_t second);
        return (second > first) ? second : first;
    endfunction

endpackage

// File: rtl/max_pool_2x2_if.sv
// Pixel stream bundle between conv stage, pooling stage and dense stage.
// Latency: n/a (wires only).
// Backpressure: none; the consumer must accept one pixel per strobe.
//   slave  : the pooling stage (consumes *_in, drives *_out)
//   master : the environment (drives *_in, consumes *_out)
interface max_pool_2x2_if #(
    parameter int DATA_WIDTH = max_pool_2x2_pkg::DATA_WIDTH
);
    import max_pool_2x2_pkg::*;

    logic                         data_valid_in;
    logic signed [DATA_WIDTH-1:0] pixel_data_in;
    logic [CNT_W-1:0]             hcount_in;
    logic [CNT_W-1:0]             vcount_in;

    logic                         data_valid_out;
    logic signed [DATA_WIDTH-1:0] pixel_data_out;
    logic [OCNT_W-1:0]            hcount_out;
    logic [OCNT_W-1:0]            vcount_out;
    logic                         frame_done_out;

    modport slave (
        input  data_valid_in, pixel_data_in, hcount_in, vcount_in,
        output data_valid_out, pixel_data_out, hcount_out, vcount_out, frame_done_out
    );

    modport master (
        output data_valid_in, pixel_data_in, hcount_in, vcount_in,
        input  data_valid_out, pixel_data_out, hcount_out, vcount_out, frame_done_out
    );

endinterface

// File: rtl/max_pool_2x2_pool_line_buffer.sv
// One-row buffer of horizontal pair maxima with a per-entry valid bit.
// Latency: 1 cycle from rd_en_i to rd_dat_o/rd_vld_o (registered read port).
// Backpressure: none; one write and one read-and-invalidate per cycle.
//   clr_all_i            : drop every valid bit (frame start)
//   wr_en_i/addr/dat     : store an entry and mark it valid
//   rd_en_i/addr         : read an entry and consume (invalidate) it
//   rd_dat_o/rd_vld_o    : registered read data and its valid bit
module pool_line_buffer #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 24,
    parameter int AW    = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    clr_all_i,
    input  logic                    wr_en_i,
    input  logic [AW-1:0]           wr_addr_i,
    input  logic signed [WIDTH-1:0] wr_dat_i,
    input  logic                    rd_en_i,
    input  logic [AW-1:0]           rd_addr_i,
    output logic signed [WIDTH-1:0] rd_dat_o,
    output logic                    rd_vld_o
);

    // Data storage carries no reset: every use is qualified by vld_q.
    logic signed [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]        vld_q, vld_d;
    logic signed [WIDTH-1:0] rd_dat_q, rd_dat_d;
    logic                    rd_vld_q, rd_vld_d;

    always_comb begin
        vld_d = clr_all_i ? '0 : vld_q;
        if (wr_en_i) begin
            vld_d[wr_addr_i] = 1'b1;
        end
        if (rd_en_i) begin
            vld_d[rd_addr_i] = 1'b0;
        end
        rd_dat_d = rd_en_i ? mem_q[rd_addr_i] : rd_dat_q;
        rd_vld_d = rd_en_i & vld_q[rd_addr_i];
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q    <= '0;
            rd_dat_q <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            rd_dat_q <= rd_dat_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    assign rd_dat_o = rd_dat_q;
    assign rd_vld_o = rd_vld_q;

endmodule

// File: rtl/max_pool_2x2.sv
// 2x2 / stride-2 signed max pooling over a raster-ordered feature map.
// Latency: 2 cycles from the odd-row/odd-column sample to data_valid_out; 1 pixel/cycle.
// Backpressure: none; idle input cycles (data_valid_in=0) simply pass time.
//   clk_in, rst_in : clock and asynchronous active-low reset
//   bus (slave)    : pixel/coordinate input stream, pooled pixel output stream
module max_pool_2x2 #(
    parameter int DATA_WIDTH = max_pool_2x2_pkg::DATA_WIDTH,
    parameter int IN_DIM     = max_pool_2x2_pkg::IN_DIM,
    parameter int OUT_DIM    = max_pool_2x2_pkg::OUT_DIM
) (
    input  logic           clk_in,
    input  logic           rst_in,
    max_pool_2x2_if.slave  bus
);
    import max_pool_2x2_pkg::*;

    localparam logic [CNT_W-1:0]  IN_LIM   = CNT_W'(IN_DIM);
    localparam logic [OCNT_W-1:0] OUT_LAST = OCNT_W'(OUT_DIM - 1);

    // ---------------- stage 0: horizontal pair, line buffer access
    pixel_t            pix_in;
    logic              accept, odd_col, odd_row, frame_start;
    logic [OCNT_W-1:0] col_in, row_in;
    pixel_t            row_max;
    logic              lb_we, lb_re;

    pixel_t pair_q, pair_d;
    logic   pair_vld_q, pair_vld_d;

    always_comb begin
        pix_in      = bus.pixel_data_in;
        accept      = bus.data_valid_in && (bus.hcount_in < IN_LIM) && (bus.vcount_in < IN_LIM);
        odd_col     = bus.hcount_in[0];
        odd_row     = bus.vcount_in[0];
        frame_start = accept && (bus.hcount_in == '0) && (bus.vcount_in == '0);
        col_in      = bus.hcount_in[CNT_W-1:1];
        row_in      = bus.vcount_in[CNT_W-1:1];

        // A lone odd column (no even partner since the last pair) passes through.
        row_max = pair_vld_q ? pool_max(pair_q, pix_in) : pix_in;

        pair_d     = pair_q;
        pair_vld_d = pair_vld_q;
        if (accept) begin
            if (!odd_col) begin
                pair_d     = pix_in;
                pair_vld_d = 1'b1;
            end else begin
                pair_vld_d = 1'b0;
            end
        end

        lb_we = accept && odd_col && !odd_row;
        lb_re = accept && odd_col && odd_row;
    end

    // ---------------- stage 1: row max aligned with the registered line buffer read
    logic              s1_vld_q, s1_vld_d;
    pixel_t            s1_max_q, s1_max_d;
    logic [OCNT_W-1:0] s1_col_q, s1_col_d;
    logic [OCNT_W-1:0] s1_row_q, s1_row_d;
    pixel_t            lb_rd_dat;
    logic              lb_rd_vld;

    pool_line_buffer #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (OUT_DIM),
        .AW    (OCNT_W)
    ) u_line_buf (
        .clk_i     (clk_in),
        .rst_n_i   (rst_in),
        .clr_all_i (frame_start),
        .wr_en_i   (lb_we),
        .wr_addr_i (col_in),
        .wr_dat_i  (row_max),
        .rd_en_i   (lb_re),
        .rd_addr_i (col_in),
        .rd_dat_o  (lb_rd_dat),
        .rd_vld_o  (lb_rd_vld)
    );

    always_comb begin
        s1_vld_d = lb_re;
        s1_max_d = lb_re ? row_max : s1_max_q;
        s1_col_d = lb_re ? col_in  : s1_col_q;
        s1_row_d = lb_re ? row_in  : s1_row_q;
    end

    // ---------------- stage 2: vertical max, registered outputs (held between strobes)
    logic              dvo_q, dvo_d;
    logic              done_q, done_d;
    pixel_t            pix_out_q, pix_out_d;
    logic [OCNT_W-1:0] hc_out_q, hc_out_d;
    logic [OCNT_W-1:0] vc_out_q, vc_out_d;

    always_comb begin
        dvo_d     = s1_vld_q;
        done_d    = s1_vld_q && (s1_col_q == OUT_LAST) && (s1_row_q == OUT_LAST);
        pix_out_d = pix_out_q;
        hc_out_d  = hc_out_q;
        vc_out_d  = vc_out_q;
        if (s1_vld_q) begin
            // The buffered even-row value is the earlier sample, so it wins ties.
            pix_out_d = lb_rd_vld ? pool_max(lb_rd_dat, s1_max_q) : s1_max_q;
            hc_out_d  = s1_col_q;
            vc_out_d  = s1_row_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pair_q     <= '0;
            pair_vld_q <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_max_q   <= '0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
            dvo_q      <= 1'b0;
            done_q     <= 1'b0;
            pix_out_q  <= '0;
            hc_out_q   <= '0;
            vc_out_q   <= '0;
        end else begin
            pair_q     <= pair_d;
            // Frame start only ever lands on an even column, which sets pair_vld anyway.
            pair_vld_q <= pair_vld_d;
            s1_vld_q   <= s1_vld_d;
            s1_max_q   <= s1_max_d;
            s1_col_q   <= s1_col_d;
            s1_row_q   <= s1_row_d;
            dvo_q      <= dvo_d;
            done_q     <= done_d;
            pix_out_q  <= pix_out_d;
            hc_out_q   <= hc_out_d;
            vc_out_q   <= vc_out_d;
        end
    end

    assign bus.data_valid_out = dvo_q;
    assign bus.frame_done_out = done_q;
    assign bus.pixel_data_out = pix_out_q;
    assign bus.hcount_out     = hc_out_q;
    assign bus.vcount_out     = vc_out_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Bench for max_pool_2x2: directed vector table, full frames, gaps, mid-frame reset.
// Latency: expects each pooled pixel exactly 2 cycles after its odd/odd sample.
// Backpressure: none; expectations are queued at drive time, popped on each strobe.
module tb_max_pool_2x2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_out = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    max_pool_2x2_if #(.DATA_WIDTH(21)) bus();

    max_pool_2x2 dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    typedef struct {
        int   pix;
        int   h;
        int   v;
        logic done;
        int   cyc;
    } exp_t;

    typedef struct {
        logic vld;
        int   h;
        int   v;
        int   pix;
        logic push;
        int   exp_pix;
    } vec_t;

    exp_t q[$];

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Present one input sample for one cycle; queue its expected result if asked.
    task automatic drive(input logic vld, input int h, input int v, input int pix,
                         input logic push, input int exp_pix);
        exp_t e;
        @(posedge clk);
        #1;
        bus.data_valid_in = vld;
        bus.hcount_in     = 6'(h);
        bus.vcount_in     = 6'(v);
        bus.pixel_data_in = 21'(pix);
        if (push) begin
            e.pix  = exp_pix;
            e.h    = h / 2;
            e.v    = v / 2;
            e.done = ((h / 2) == 23) && ((v / 2) == 23);
            e.cyc  = cyc + 2;
            q.push_back(e);
        end
    endtask

    task automatic idle();
        drive(1'b0, int'($urandom_range(47, 0)), int'($urandom_range(47, 0)),
              int'($urandom_range(2000, 0)), 1'b0, 0);
    endtask

    task automatic drain(input string name);
        repeat (6) idle();
        check(name, q.size(), 0);
    endtask

    // const9=0: ramp pixel = h+48*v; const9=1: every pixel 9.
    task automatic send_frame(input bit const9, input bit gaps);
        int pix, expv;
        for (int v = 0; v < 48; v++) begin
            for (int h = 0; h < 48; h++) begin
                if (gaps && ($urandom_range(1, 0) == 1)) begin
                    repeat ($urandom_range(3, 1)) idle();
                end
                pix  = const9 ? 9 : h + 48 * v;
                expv = const9 ? 9 : (2 * (h / 2) + 1) + 48 * (2 * (v / 2) + 1);
                drive(1'b1, h, v, pix, (h % 2 == 1) && (v % 2 == 1), expv);
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_dvo"},  {31'd0, bus.data_valid_out}, 0);
        check({tag, "_done"}, {31'd0, bus.frame_done_out}, 0);
        check({tag, "_pix"},  bus.pixel_data_out, 0);
        check({tag, "_hc"},   {27'd0, bus.hcount_out}, 0);
        check({tag, "_vc"},   {27'd0, bus.vcount_out}, 0);
    endtask

    // Scoreboard side: compare every strobe against the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (bus.data_valid_out) begin
            n_out++;
            if (q.size() == 0) begin
                check("unexpected_output_hc", {27'd0, bus.hcount_out}, -1);
            end else begin
                e = q.pop_front();
                check("out_pixel",   bus.pixel_data_out, e.pix);
                check("out_hcount",  {27'd0, bus.hcount_out}, e.h);
                check("out_vcount",  {27'd0, bus.vcount_out}, e.v);
                check("out_done",    {31'd0, bus.frame_done_out}, {31'd0, e.done});
                check("out_latency", cyc, e.cyc);
            end
        end else begin
            check("done_without_valid", {31'd0, bus.frame_done_out}, 0);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[19];
        int   base;

        bus.data_valid_in = 1'b0;
        bus.hcount_in     = '0;
        bus.vcount_in     = '0;
        bus.pixel_data_in = '0;

        vecs[0]  = '{1'b1, 0, 0, -5,        1'b0, 0};
        vecs[1]  = '{1'b1, 1, 0, -3,        1'b0, 0};
        vecs[2]  = '{1'b1, 0, 1, -7,        1'b0, 0};
        vecs[3]  = '{1'b1, 1, 1, -100,      1'b1, -3};
        vecs[4]  = '{1'b1, 2, 0, 'h0FFFFF,  1'b0, 0};
        vecs[5]  = '{1'b1, 3, 0, 3,         1'b0, 0};
        vecs[6]  = '{1'b1, 2, 1, -1,        1'b0, 0};
        vecs[7]  = '{1'b1, 3, 1, 'h0FFFFF,  1'b1, 'h0FFFFF};
        vecs[8]  = '{1'b1, 4, 0, -1048576,  1'b0, 0};
        vecs[9]  = '{1'b1, 5, 0, -1048576,  1'b0, 0};
        vecs[10] = '{1'b1, 4, 1, -1048576,  1'b0, 0};
        vecs[11] = '{1'b1, 5, 1, -1048576,  1'b1, -1048576};
        vecs[12] = '{1'b1, 50, 0, 777,      1'b0, 0};
        vecs[13] = '{1'b1, 13, 63, 500,     1'b0, 0};
        vecs[14] = '{1'b1, 7, 1, 11,        1'b1, 11};
        vecs[15] = '{1'b0, 8, 0, 888,       1'b0, 0};
        vecs[16] = '{1'b1, 9, 0, 20,        1'b0, 0};
        vecs[17] = '{1'b1, 8, 1, -50,       1'b0, 0};
        vecs[18] = '{1'b1, 9, 1, -60,       1'b1, 20};

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Directed blocks: ordering, ties, extremes, ignored and missing operands.
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].vld, vecs[i].h, vecs[i].v, vecs[i].pix, vecs[i].push, vecs[i].exp_pix);
        end
        drain("table_drain");

        // Full ramp frame, back to back.
        base = n_out;
        send_frame(1'b0, 1'b0);
        drain("frame_drain");
        check("frame_count", n_out - base, 576);

        // Same frame with random idle gaps.
        base = n_out;
        send_frame(1'b0, 1'b1);
        drain("gap_frame_drain");
        check("gap_frame_count", n_out - base, 576);

        // Reset in the middle of row 17; the (19,17) result must never appear.
        for (int v = 0; v < 17; v++) begin
            for (int h = 0; h < 48; h++) begin
                drive(1'b1, h, v, h + 48 * v, (h % 2 == 1) && (v % 2 == 1),
                      (2 * (h / 2) + 1) + 48 * (2 * (v / 2) + 1));
            end
        end
        for (int h = 0; h < 20; h++) begin
            drive(1'b1, h, 17, h + 48 * 17, (h % 2 == 1) && (h < 19), h + 48 * 17);
        end
        @(posedge clk);
        #1;
        bus.data_valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) idle();
        check("stale_queue", q.size(), 0);

        // Row 16 column 10 was buffered before reset; it must not leak in.
        drive(1'b1, 21, 17, 9, 1'b1, 9);
        drain("post_reset_single");

        base = n_out;
        send_frame(1'b1, 1'b1);
        drain("const_frame_drain");
        check("const_frame_count", n_out - base, 576);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
